// File: rtl/axi_pkg.sv
// Shared AXI burst definitions: burst encodings, the 4 KB boundary and the
// burst-sequencer state type.
package axi_pkg;

   localparam logic [1:0] BURST_FIXED = 2'b00;
   localparam logic [1:0] BURST_INCR  = 2'b01;
   localparam logic [1:0] BURST_WRAP  = 2'b10;
   localparam logic [1:0] BURST_RSVD  = 2'b11;

   // A burst must not cross a 4 KB page (address bit 12 and above).
   localparam int BOUNDARY_4K_SHIFT = 12;

   typedef enum logic {
      IDLE  = 1'b0,
      BURST = 1'b1
   } burst_state_e;

endpackage

// File: rtl/axi_burst_addr_seq_if.sv
// Request (AR/AW) and per-beat address bundle between the address front end,
// the burst sequencer and the data-path beat engine.
interface axi_burst_addr_seq_if #(
   parameter int ADDR_W = 32,
   parameter int LEN_W  = 8
);

   // Both channels are valid/ready: a transfer happens on a clock edge where
   // valid && ready; the source holds its payload stable while valid && !ready.
   logic              a_valid;
   logic              a_ready;
   logic [ADDR_W-1:0] a_addr;
   logic [LEN_W-1:0]  a_len;
   logic [2:0]        a_size;
   logic [1:0]        a_burst;

   logic              beat_valid;
   logic              beat_ready;
   logic [ADDR_W-1:0] beat_addr;
   logic              beat_last;
   logic [LEN_W-1:0]  beat_cnt;
   logic              beat_err;

   modport slave (
      input  a_valid, a_addr, a_len, a_size, a_burst, beat_ready,
      output a_ready, beat_valid, beat_addr, beat_last, beat_cnt, beat_err
   );

   modport master (
      output a_valid, a_addr, a_len, a_size, a_burst, beat_ready,
      input  a_ready, beat_valid, beat_addr, beat_last, beat_cnt, beat_err
   );

endinterface

// File: rtl/axi_next_addr.sv
// Combinational next-beat address for FIXED, INCR and WRAP bursts. The caller
// passes the effective burst type (illegal WRAP / reserved already mapped to INCR).
module axi_next_addr
   import axi_pkg::*;
#(
   parameter int ADDR_W = 32,
   parameter int LEN_W  = 8
) (
   input  logic [ADDR_W-1:0] cur_i,
   input  logic [ADDR_W-1:0] start_i,
   input  logic [LEN_W-1:0]  len_i,
   input  logic [2:0]        size_i,
   input  logic [1:0]        burst_i,
   output logic [ADDR_W-1:0] next_o
);

   logic [ADDR_W-1:0] bytes;
   logic [ADDR_W-1:0] wrap_bytes;
   logic [ADDR_W-1:0] wrap_low;
   logic [ADDR_W-1:0] step;

   always_comb begin
      bytes      = ADDR_W'(1) << size_i;
      wrap_bytes = (ADDR_W'(len_i) + ADDR_W'(1)) << size_i;
      wrap_low   = start_i & ~(wrap_bytes - ADDR_W'(1));
      step       = cur_i + bytes;
      next_o     = cur_i;
      case (burst_i)
         BURST_FIXED: next_o = cur_i;
         BURST_WRAP:  next_o = (step == wrap_low + wrap_bytes) ? wrap_low : step;
         // INCR realigns after a possibly unaligned first beat.
         default:     next_o = (cur_i & ~(bytes - ADDR_W'(1))) + bytes;
      endcase
   end

endmodule

// File: rtl/axi_burst_addr_seq.sv
// AXI4 burst address sequencer: accepts one AR/AW request, then emits one
// registered beat address per beat handshake, with last-beat and error flags.
module axi_burst_addr_seq
   import axi_pkg::*;
#(
   parameter int ADDR_W   = 32,
   parameter int LEN_W    = 8,
   parameter int MAX_SIZE = 2
) (
   input  logic                clk,
   input  logic                rst,
   axi_burst_addr_seq_if.slave bus,
   output burst_state_e        dbg_state_o
);

   burst_state_e      state_q, state_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [ADDR_W-1:0] start_q, start_d;
   logic [LEN_W-1:0]  len_q, len_d;
   logic [LEN_W-1:0]  cnt_q, cnt_d;
   logic [2:0]        size_q, size_d;
   logic [1:0]        burst_q, burst_d;
   logic              last_q, last_d;
   logic              err_q, err_d;
   logic [ADDR_W-1:0] next_addr;

   logic [ADDR_W-1:0] a_bytes;
   logic [ADDR_W-1:0] a_end;
   logic              a_cross;
   logic              wrap_len_ok;
   logic              wrap_bad;
   logic              acc_err;
   logic [1:0]        eff_burst;

   // Legality of the incoming request; only consumed on the accept cycle.
   always_comb begin
      a_bytes     = ADDR_W'(1) << bus.a_size;
      a_end       = (bus.a_addr & ~(a_bytes - ADDR_W'(1)))
                  + ((ADDR_W'(bus.a_len) + ADDR_W'(1)) << bus.a_size) - ADDR_W'(1);
      a_cross     = (bus.a_addr >> BOUNDARY_4K_SHIFT) != (a_end >> BOUNDARY_4K_SHIFT);
      wrap_len_ok = (bus.a_len == LEN_W'(1)) || (bus.a_len == LEN_W'(3)) ||
                    (bus.a_len == LEN_W'(7)) || (bus.a_len == LEN_W'(15));
      wrap_bad    = (bus.a_burst == BURST_WRAP) &&
                    (!wrap_len_ok || ((bus.a_addr & (a_bytes - ADDR_W'(1))) != '0));
      acc_err     = (int'(bus.a_size) > MAX_SIZE) || wrap_bad ||
                    ((bus.a_burst == BURST_FIXED) && (bus.a_len > LEN_W'(15))) ||
                    (bus.a_burst == BURST_RSVD) ||
                    ((bus.a_burst == BURST_INCR) && a_cross);
      eff_burst   = (wrap_bad || (bus.a_burst == BURST_RSVD)) ? BURST_INCR : bus.a_burst;
   end

   axi_next_addr #(
      .ADDR_W (ADDR_W),
      .LEN_W  (LEN_W)
   ) u_next_addr (
      .cur_i   (addr_q),
      .start_i (start_q),
      .len_i   (len_q),
      .size_i  (size_q),
      .burst_i (burst_q),
      .next_o  (next_addr)
   );

   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      start_d = start_q;
      len_d   = len_q;
      cnt_d   = cnt_q;
      size_d  = size_q;
      burst_d = burst_q;
      last_d  = last_q;
      err_d   = err_q;
      case (state_q)
         IDLE: begin
            if (bus.a_valid) begin
               state_d = BURST;
               addr_d  = bus.a_addr;
               start_d = bus.a_addr;
               len_d   = bus.a_len;
               size_d  = bus.a_size;
               burst_d = eff_burst;
               cnt_d   = '0;
               last_d  = (bus.a_len == '0);
               err_d   = acc_err;
            end
         end
         BURST: begin
            if (bus.beat_ready) begin
               if (last_q) begin
                  state_d = IDLE;
                  last_d  = 1'b0;
               end else begin
                  cnt_d  = cnt_q + LEN_W'(1);
                  addr_d = next_addr;
                  last_d = ((cnt_q + LEN_W'(1)) == len_q);
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         addr_q  <= '0;
         start_q <= '0;
         len_q   <= '0;
         cnt_q   <= '0;
         size_q  <= '0;
         burst_q <= '0;
         last_q  <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         start_q <= start_d;
         len_q   <= len_d;
         cnt_q   <= cnt_d;
         size_q  <= size_d;
         burst_q <= burst_d;
         last_q  <= last_d;
         err_q   <= err_d;
      end
   end

   assign bus.a_ready    = (state_q == IDLE);
   assign bus.beat_valid = (state_q == BURST);
   assign bus.beat_addr  = addr_q;
   assign bus.beat_cnt   = cnt_q;
   assign bus.beat_last  = last_q;
   assign bus.beat_err   = err_q;
   assign dbg_state_o    = state_q;

endmodule

// File: tb/tb_axi_burst_addr_seq.sv
// Directed bench for axi_burst_addr_seq: FIXED/INCR/WRAP sequences, backpressure,
// error flagging, back-to-back requests and reset in the middle of a burst.
module tb_axi_burst_addr_seq;
   import axi_pkg::*;

   logic         clk;
   logic         rst;
   burst_state_e dbg_state;
   int           errors = 0;
   int           checks = 0;

   axi_burst_addr_seq_if #(.ADDR_W(32), .LEN_W(8)) bus ();

   axi_burst_addr_seq #(
      .ADDR_W   (32),
      .LEN_W    (8),
      .MAX_SIZE (2)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .bus         (bus.slave),
      .dbg_state_o (dbg_state)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Driver: wait (bounded) for a_ready, present one request for one edge.
   task automatic send_req(input logic [31:0] addr, input logic [7:0] len,
                           input logic [2:0] size, input logic [1:0] burst,
                           output bit ok);
      ok = 1'b0;
      for (int k = 0; k < 50; k++) begin
         @(negedge clk);
         if (bus.a_ready === 1'b1) begin
            ok = 1'b1;
            break;
         end
      end
      bus.a_valid = 1'b1;
      bus.a_addr  = addr;
      bus.a_len   = len;
      bus.a_size  = size;
      bus.a_burst = burst;
      @(posedge clk);
      #1;
      bus.a_valid = 1'b0;
   endtask

   // Driver: wait (bounded) for a beat, sample it at negedge, then consume it.
   task automatic get_beat(output bit ok, output int waited, output logic [31:0] addr,
                           output logic [7:0] cnt, output logic last, output logic err);
      ok = 1'b0;
      waited = 0;
      while (waited < 50) begin
         @(negedge clk);
         if (bus.beat_valid === 1'b1) begin
            ok = 1'b1;
            break;
         end
         waited++;
      end
      addr = bus.beat_addr;
      cnt  = bus.beat_cnt;
      last = bus.beat_last;
      err  = bus.beat_err;
      if (ok) begin
         bus.beat_ready = 1'b1;
         @(posedge clk);
         #1;
         bus.beat_ready = 1'b0;
      end
   endtask

   task automatic test_reset();
      rst            = 1'b1;
      bus.a_valid    = 1'b0;
      bus.a_addr     = '0;
      bus.a_len      = '0;
      bus.a_size     = '0;
      bus.a_burst    = '0;
      bus.beat_ready = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      checks++;
      if ({bus.a_ready, bus.beat_valid, bus.beat_last, bus.beat_err, bus.beat_addr,
           bus.beat_cnt, dbg_state} !== {1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 8'h0, IDLE}) begin
         errors++;
         $display("FAIL reset_state: a_ready=%b valid=%b last=%b err=%b addr=%h cnt=%0d st=%0d, expected 1 0 0 0 0 0 IDLE",
                  bus.a_ready, bus.beat_valid, bus.beat_last, bus.beat_err, bus.beat_addr,
                  bus.beat_cnt, dbg_state);
      end
      rst = 1'b0;
   endtask

   task automatic test_incr();
      logic [31:0] exp_a [4] = '{32'h1000, 32'h1004, 32'h1008, 32'h100C};
      bit ok; int w; logic [31:0] a; logic [7:0] c; logic l, e;
      send_req(32'h1000, 8'd3, 3'd2, BURST_INCR, ok);
      for (int i = 0; i < 4; i++) begin
         get_beat(ok, w, a, c, l, e);
         checks++;
         if (!ok || w != 0 || {a, c, l, e} !== {exp_a[i], 8'(i), 1'(i == 3), 1'b0}) begin
            errors++;
            $display("FAIL incr_beat%0d: ok=%b wait=%0d addr=%h cnt=%0d last=%b err=%b, expected addr=%h cnt=%0d last=%b err=0 wait=0",
                     i, ok, w, a, c, l, e, exp_a[i], i, (i == 3));
         end
      end
      @(negedge clk);
      checks++;
      if ({bus.a_ready, bus.beat_valid} !== 2'b10) begin
         errors++;
         $display("FAIL incr_return_idle: a_ready=%b beat_valid=%b, expected 1 0",
                  bus.a_ready, bus.beat_valid);
      end
   endtask

   task automatic test_wrap();
      logic [31:0] start_t [2] = '{32'h1038, 32'h2006};
      logic [7:0]  len_t   [2] = '{8'd3, 8'd7};
      logic [2:0]  size_t  [2] = '{3'd2, 3'd1};
      logic [31:0] exp_a [2][8] = '{
         '{32'h1038, 32'h103C, 32'h1030, 32'h1034, 32'h0, 32'h0, 32'h0, 32'h0},
         '{32'h2006, 32'h2008, 32'h200A, 32'h200C, 32'h200E, 32'h2000, 32'h2002, 32'h2004}};
      bit ok; int w; logic [31:0] a; logic [7:0] c; logic l, e;
      for (int t = 0; t < 2; t++) begin
         send_req(start_t[t], len_t[t], size_t[t], BURST_WRAP, ok);
         for (int i = 0; i <= int'(len_t[t]); i++) begin
            get_beat(ok, w, a, c, l, e);
            checks++;
            if (!ok || {a, c, l, e} !== {exp_a[t][i], 8'(i), 1'(i == int'(len_t[t])), 1'b0}) begin
               errors++;
               $display("FAIL wrap%0d_beat%0d: ok=%b addr=%h cnt=%0d last=%b err=%b, expected addr=%h cnt=%0d last=%b err=0",
                        t, i, ok, a, c, l, e, exp_a[t][i], i, (i == int'(len_t[t])));
            end
         end
      end
   endtask

   task automatic test_fixed();
      bit ok; int w; logic [31:0] a; logic [7:0] c; logic l, e;
      send_req(32'h2000, 8'd2, 3'd2, BURST_FIXED, ok);
      for (int i = 0; i < 3; i++) begin
         get_beat(ok, w, a, c, l, e);
         checks++;
         if (!ok || {a, c, l, e} !== {32'h2000, 8'(i), 1'(i == 2), 1'b0}) begin
            errors++;
            $display("FAIL fixed_beat%0d: ok=%b addr=%h cnt=%0d last=%b err=%b, expected addr=00002000 cnt=%0d last=%b err=0",
                     i, ok, a, c, l, e, i, (i == 2));
         end
      end
      // 17-beat FIXED is illegal but must still complete at a constant address.
      send_req(32'h2100, 8'd16, 3'd2, BURST_FIXED, ok);
      for (int i = 0; i < 17; i++) begin
         get_beat(ok, w, a, c, l, e);
         checks++;
         if (!ok || {a, c, l, e} !== {32'h2100, 8'(i), 1'(i == 16), 1'b1}) begin
            errors++;
            $display("FAIL fixed_long_beat%0d: ok=%b addr=%h cnt=%0d last=%b err=%b, expected addr=00002100 cnt=%0d last=%b err=1",
                     i, ok, a, c, l, e, i, (i == 16));
         end
      end
   endtask

   task automatic test_unaligned();
      logic [31:0] exp_a [3] = '{32'h1003, 32'h1004, 32'h1008};
      bit ok; int w; logic [31:0] a; logic [7:0] c; logic l, e;
      send_req(32'h1003, 8'd2, 3'd2, BURST_INCR, ok);
      for (int i = 0; i < 3; i++) begin
         get_beat(ok, w, a, c, l, e);
         checks++;
         if (!ok || {a, c, l, e} !== {exp_a[i], 8'(i), 1'(i == 2), 1'b0}) begin
            errors++;
            $display("FAIL unaligned_beat%0d: ok=%b addr=%h cnt=%0d last=%b err=%b, expected addr=%h cnt=%0d last=%b err=0",
                     i, ok, a, c, l, e, exp_a[i], i, (i == 2));
         end
      end
   endtask

   task automatic test_backpressure();
      bit ok; int w; logic [31:0] a; logic [7:0] c; logic l, e;
      send_req(32'h3000, 8'd1, 3'd2, BURST_INCR, ok);
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         checks++;
         if ({bus.beat_valid, bus.beat_addr, bus.beat_cnt, bus.beat_last} !== {1'b1, 32'h3000, 8'd0, 1'b0}) begin
            errors++;
            $display("FAIL bp_hold%0d: valid=%b addr=%h cnt=%0d last=%b, expected 1 00003000 0 0",
                     k, bus.beat_valid, bus.beat_addr, bus.beat_cnt, bus.beat_last);
         end
      end
      get_beat(ok, w, a, c, l, e);
      checks++;
      if (!ok || {a, c, l} !== {32'h3000, 8'd0, 1'b0}) begin
         errors++;
         $display("FAIL bp_beat0: ok=%b addr=%h cnt=%0d last=%b, expected 00003000 0 0", ok, a, c, l);
      end
      get_beat(ok, w, a, c, l, e);
      checks++;
      if (!ok || {a, c, l, e} !== {32'h3004, 8'd1, 1'b1, 1'b0}) begin
         errors++;
         $display("FAIL bp_beat1: ok=%b addr=%h cnt=%0d last=%b err=%b, expected 00003004 1 1 0", ok, a, c, l, e);
      end
   endtask

   task automatic test_errors();
      logic [31:0] addr_t  [6] = '{32'h0FF8, 32'h1038, 32'h0100, 32'h0FFC, 32'h0200, 32'h1035};
      logic [7:0]  len_t   [6] = '{8'd1, 8'd2, 8'd0, 8'd1, 8'd1, 8'd3};
      logic [2:0]  size_t  [6] = '{3'd3, 3'd2, 3'd3, 3'd2, 3'd2, 3'd2};
      logic [1:0]  burst_t [6] = '{BURST_INCR, BURST_WRAP, BURST_INCR, BURST_INCR, BURST_RSVD, BURST_WRAP};
      logic [31:0] exp_a [6][4] = '{
         '{32'h0FF8, 32'h1000, 32'h0, 32'h0},
         '{32'h1038, 32'h103C, 32'h1040, 32'h0},
         '{32'h0100, 32'h0, 32'h0, 32'h0},
         '{32'h0FFC, 32'h1000, 32'h0, 32'h0},
         '{32'h0200, 32'h0204, 32'h0, 32'h0},
         '{32'h1035, 32'h1038, 32'h103C, 32'h1040}};
      bit ok; int w; logic [31:0] a; logic [7:0] c; logic l, e;
      for (int t = 0; t < 6; t++) begin
         send_req(addr_t[t], len_t[t], size_t[t], burst_t[t], ok);
         for (int i = 0; i <= int'(len_t[t]); i++) begin
            get_beat(ok, w, a, c, l, e);
            checks++;
            if (!ok || {a, c, l, e} !== {exp_a[t][i], 8'(i), 1'(i == int'(len_t[t])), 1'b1}) begin
               errors++;
               $display("FAIL err%0d_beat%0d: ok=%b addr=%h cnt=%0d last=%b err=%b, expected addr=%h cnt=%0d last=%b err=1",
                        t, i, ok, a, c, l, e, exp_a[t][i], i, (i == int'(len_t[t])));
            end
         end
      end
   endtask

   task automatic test_back_to_back();
      bit ok; int w; logic [31:0] a; logic [7:0] c; logic l, e;
      send_req(32'h6000, 8'd1, 3'd2, BURST_INCR, ok);
      @(negedge clk);
      bus.a_valid = 1'b1;
      bus.a_addr  = 32'h7000;
      bus.a_len   = 8'd0;
      bus.a_size  = 3'd2;
      bus.a_burst = BURST_FIXED;
      checks++;
      if ({bus.a_ready, bus.beat_valid} !== 2'b01) begin
         errors++;
         $display("FAIL b2b_busy: a_ready=%b beat_valid=%b, expected 0 1", bus.a_ready, bus.beat_valid);
      end
      for (int i = 0; i < 2; i++) begin
         get_beat(ok, w, a, c, l, e);
         checks++;
         if (!ok || {a, c, l} !== {32'h6000 + 32'(4 * i), 8'(i), 1'(i == 1)}) begin
            errors++;
            $display("FAIL b2b_first%0d: ok=%b addr=%h cnt=%0d last=%b, expected addr=%h cnt=%0d last=%b",
                     i, ok, a, c, l, 32'h6000 + 32'(4 * i), i, (i == 1));
         end
      end
      @(negedge clk);
      checks++;
      if ({bus.a_ready, bus.beat_valid} !== 2'b10) begin
         errors++;
         $display("FAIL b2b_bubble: a_ready=%b beat_valid=%b, expected 1 0", bus.a_ready, bus.beat_valid);
      end
      @(posedge clk);
      #1;
      bus.a_valid = 1'b0;
      get_beat(ok, w, a, c, l, e);
      checks++;
      if (!ok || w != 0 || {a, c, l, e} !== {32'h7000, 8'd0, 1'b1, 1'b0}) begin
         errors++;
         $display("FAIL b2b_second: ok=%b wait=%0d addr=%h cnt=%0d last=%b err=%b, expected wait=0 00007000 0 1 0",
                  ok, w, a, c, l, e);
      end
   endtask

   task automatic test_reset_mid_burst();
      bit ok; int w; logic [31:0] a; logic [7:0] c; logic l, e;
      send_req(32'h4000, 8'd7, 3'd2, BURST_INCR, ok);
      get_beat(ok, w, a, c, l, e);
      get_beat(ok, w, a, c, l, e);
      @(negedge clk);
      checks++;
      if ({bus.beat_valid, bus.beat_addr, bus.beat_cnt, dbg_state} !== {1'b1, 32'h4008, 8'd2, BURST}) begin
         errors++;
         $display("FAIL rst_mid_before: valid=%b addr=%h cnt=%0d st=%0d, expected 1 00004008 2 BURST",
                  bus.beat_valid, bus.beat_addr, bus.beat_cnt, dbg_state);
      end
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      checks++;
      if ({bus.a_ready, bus.beat_valid, bus.beat_last, bus.beat_err, bus.beat_addr, bus.beat_cnt}
          !== {1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 8'h0}) begin
         errors++;
         $display("FAIL rst_mid_after: a_ready=%b valid=%b last=%b err=%b addr=%h cnt=%0d, expected 1 0 0 0 0 0",
                  bus.a_ready, bus.beat_valid, bus.beat_last, bus.beat_err, bus.beat_addr, bus.beat_cnt);
      end
      repeat (3) @(negedge clk);
      checks++;
      if (bus.beat_valid !== 1'b0) begin
         errors++;
         $display("FAIL rst_mid_abandon: beat_valid=%b, expected 0", bus.beat_valid);
      end
      send_req(32'h5000, 8'd0, 3'd2, BURST_INCR, ok);
      get_beat(ok, w, a, c, l, e);
      checks++;
      if (!ok || w != 0 || {a, c, l, e} !== {32'h5000, 8'd0, 1'b1, 1'b0}) begin
         errors++;
         $display("FAIL rst_mid_new: ok=%b wait=%0d addr=%h cnt=%0d last=%b err=%b, expected wait=0 00005000 0 1 0",
                  ok, w, a, c, l, e);
      end
   endtask

   initial begin
      test_reset();
      test_incr();
      test_wrap();
      test_fixed();
      test_unaligned();
      test_backpressure();
      test_errors();
      test_back_to_back();
      test_reset_mid_burst();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, expected bench to finish");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/axi_burst_addr_seq.md
Name: axi_burst_addr_seq

Overview:
Sequencer for AXI4 burst address generation. It accepts one address-channel request (AR or AW) via valid/ready and then issues one per-beat address per handshake on a beat interface. It implements FIXED, INCR and WRAP bursts, drives the last-beat flag and flags protocol violations. It sits between the slave address-channel front end and the read/write data-path beat engines, replacing free-running address incrementers.

Parameters:
ADDR_W, 32, address width
LEN_W, 8, AxLEN width (AXI4: up to 256 beats)
MAX_SIZE, 2, log2 of data-bus bytes; AxSIZE above this is illegal

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset, synchronous, active-high
a_valid  in  1  address request valid
a_ready  out  1  block can accept a request
a_addr  in  ADDR_W  start address (AxADDR)
a_len  in  LEN_W  beats minus one (AxLEN)
a_size  in  3  log2 bytes per beat (AxSIZE)
a_burst  in  2  00 FIXED, 01 INCR, 10 WRAP, 11 reserved
beat_valid  out  1  beat_addr valid
beat_ready  in  1  data path consumes the current beat
beat_addr  out  ADDR_W  address of the current beat
beat_last  out  1  current beat is the final beat
beat_cnt  out  LEN_W  index of the current beat, 0-based
beat_err  out  1  burst has a protocol violation; constant for the whole burst

Behaviour:
- The design uses one clock and one reset. Reset is synchronous and active-high on rst; there is no asynchronous reset path.
- FSM states:
  - IDLE: a_ready=1, beat_valid=0.
  - BURST: a_ready=0, beat_valid=1.
- Reset, including reset mid-burst: FSM goes to IDLE. a_ready=1. beat_valid, beat_last, beat_err, beat_addr and beat_cnt all =0. The in-flight burst is abandoned, with no further beats.
- IDLE to BURST on a_valid&&a_ready:
  - Capture addr, len, size and burst.
  - From the next cycle: beat_addr=a_addr (unaligned allowed), beat_cnt=0, beat_last=(a_len==0).
  - Request-to-first-beat latency is 1 cycle.
- Each beat_valid&&beat_ready in BURST:
  - If beat_last: go to IDLE. a_ready=1 the next cycle, so there is a 1-cycle bubble between bursts and no same-cycle re-accept.
  - Otherwise: beat_cnt+1, beat_addr = next address, beat_last=(beat_cnt+1==len).
- Outputs are registered and held stable while beat_valid&&!beat_ready.
- Next-address rules (bytes = 1<<size; aligned = addr & ~(bytes-1)):
  - FIXED: address unchanged for every beat.
  - INCR: next = aligned + bytes. The first beat may be unaligned; all later beats are aligned.
  - WRAP: wrap_bytes=(len+1)<<size; low = start & ~(wrap_bytes-1). next = cur + bytes; if next == low + wrap_bytes, then next = low.
  - Reserved (11): treated as INCR, beat_err=1.
- beat_err is computed at accept and registered for the whole burst. It is set by any of:
  - size > MAX_SIZE
  - WRAP with len not in {1,3,7,15}, or WRAP with an unaligned start address
  - FIXED with len>15
  - burst==11
  - an INCR burst whose last byte crosses a 4 KB boundary (start[ADDR_W-1:12] != end[ADDR_W-1:12])
- On an error the block still issues len+1 beats. Address rules still apply, and an illegal WRAP uses INCR.
- Arithmetic is done at ADDR_W. Overflow at the top of the address space wraps modulo 2^ADDR_W with no extra flag (the 4 KB check covers it).
- a_valid while in BURST is ignored (a_ready=0). The request stays pending until IDLE.

Decomposition:
- Shared package axi_pkg: BURST_FIXED/INCR/WRAP/RSVD constants, 4 KB boundary constant, and a burst-state enum {IDLE, BURST}. ADDR_W and LEN_W defaults are not part of the package.
- One sub-module, axi_next_addr: purely combinational next-address and wrap-boundary calculation, taking (cur, start, len, size, burst). This lets it be reused by the write and read sides.

Test Plan:
- INCR addr=0x1000 len=3 size=2, beat_ready=1 -> beats 0x1000, 0x1004, 0x1008, 0x100C; beat_last only on the 4th; beat_err=0; a_ready high 1 cycle after the last beat.
- WRAP addr=0x1038 len=3 size=2 -> 0x1038, 0x103C, 0x1030, 0x1034; beat_err=0.
- FIXED addr=0x2000 len=2 -> 0x2000 three times, beat_cnt 0, 1, 2. Unaligned INCR addr=0x1003 size=2 len=2 -> 0x1003, 0x1004, 0x1008.
- Backpressure: INCR 0x3000 len=1 size=2, beat_ready low 3 cycles on beat 0 -> beat_addr held at 0x3000, beat_cnt=0, beat_last=0; then 0x3004 with last=1.
- Errors: INCR 0x0FF8 size=3 len=1 -> 0x0FF8, 0x1000 with beat_err=1. WRAP len=2 -> beat_err=1 with INCR addresses. size=3 -> beat_err=1.
- Reset mid-burst: assert rst on beat 2 of a len=7 INCR burst -> next cycle beat_valid=0, all outputs 0, a_ready=1. A new request is then accepted normally.
